// File: rtl/hd63701_pkg.sv
`default_nettype none
// ============================================================================
// Module  : hd63701_pkg
// Brief   : Shared constants, FSM encodings and baud divider table for the
//           HD63701 serial communication interface.
// Revision: 1.0
// ============================================================================
package hd63701_pkg;

    // Register offsets from BASE
    localparam logic [1:0] c_OFF_RMCR  = 2'd0;
    localparam logic [1:0] c_OFF_TRCSR = 2'd1;
    localparam logic [1:0] c_OFF_RDR   = 2'd2;
    localparam logic [1:0] c_OFF_TDR   = 2'd3;

    // TRCSR bit positions
    localparam int c_BIT_RDRF = 7;
    localparam int c_BIT_ORFE = 6;
    localparam int c_BIT_TDRE = 5;
    localparam int c_BIT_RIE  = 4;
    localparam int c_BIT_RE   = 3;
    localparam int c_BIT_TIE  = 2;
    localparam int c_BIT_TE   = 1;
    localparam int c_BIT_WU   = 0;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_e;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_e;

    // Terminal prescaler count for each SS setting (divide by 1/8/64/256)
    function automatic logic [7:0] ss_last(input logic [1:0] ss);
        logic [7:0] v;
        case (ss)
            2'b00:   v = 8'd0;
            2'b01:   v = 8'd7;
            2'b10:   v = 8'd63;
            default: v = 8'd255;
        endcase
        return v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/hd63701_sci_baud.sv
`default_nettype none
// ============================================================================
// Module  : hd63701_sci_baud
// Brief   : SCI prescaler; emits the sample tick and the /16 bit tick.
// Revision: 1.0
// ============================================================================
module hd63701_sci_baud
    import hd63701_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_clr,
    input  logic [1:0] i_ss,
    output logic       o_sample_tick,
    output logic       o_bit_tick
);

    logic [7:0] r_pre;
    logic [3:0] r_sub;
    logic [7:0] w_last;
    logic       w_pre_wrap;

    assign w_last     = ss_last(i_ss);
    assign w_pre_wrap = (r_pre >= w_last);

    // Suppress ticks in the clearing cycle so a divider change starts cleanly
    assign o_sample_tick = w_pre_wrap && !i_clr;
    assign o_bit_tick    = o_sample_tick && (r_sub == 4'hF);

    always_ff @(posedge i_clk) begin
        if (i_rst || i_clr) begin
            r_pre <= 8'd0;
            r_sub <= 4'd0;
        end else if (w_pre_wrap) begin
            r_pre <= 8'd0;
            r_sub <= r_sub + 4'd1;
        end else begin
            r_pre <= r_pre + 8'd1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/hd63701_sci.sv
`default_nettype none
// ============================================================================
// Module  : hd63701_sci
// Brief   : HD63701 SCI, async 8N1 mode, on the core bus with IRQ2 request.
// Revision: 1.0
// ============================================================================
module hd63701_sci
    import hd63701_pkg::*;
#(
    parameter logic [15:0] BASE        = 16'h0010,
    parameter int          SYNC_STAGES = 2
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        BUS_EN,
    input  logic [15:0] AD,
    input  logic        RW,
    input  logic [7:0]  WDATA,
    output logic [7:0]  RDATA,
    output logic        SEL,
    output logic        IRQ,
    input  logic        RXD,
    output logic        TXD
);

    // ------------------------------------------------------------------
    // Bus decode
    // ------------------------------------------------------------------
    logic [15:0] w_off;
    logic [1:0]  w_reg;
    logic        w_acc, w_rd, w_wr;
    logic        w_rmcr_wr, w_trcsr_wr, w_tdr_wr, w_trcsr_rd, w_rdr_rd;

    assign w_off = AD - BASE;
    assign w_reg = w_off[1:0];
    assign w_acc = BUS_EN && (w_off[15:2] == 14'd0);
    assign w_rd  = w_acc && RW;
    assign w_wr  = w_acc && !RW;
    assign SEL   = w_rd;

    assign w_rmcr_wr  = w_wr && (w_reg == c_OFF_RMCR);
    assign w_trcsr_wr = w_wr && (w_reg == c_OFF_TRCSR);
    assign w_tdr_wr   = w_wr && (w_reg == c_OFF_TDR);
    assign w_trcsr_rd = w_rd && (w_reg == c_OFF_TRCSR);
    assign w_rdr_rd   = w_rd && (w_reg == c_OFF_RDR);

    // ------------------------------------------------------------------
    // Registers and flags
    // ------------------------------------------------------------------
    logic [7:0] r_rmcr, r_rdr, r_tdr;
    logic [4:0] r_ctl;
    logic       r_rdrf, r_orfe, r_tdre;
    logic       r_rx_arm, r_tx_arm, r_irq;
    logic [7:0] w_trcsr;

    assign w_trcsr = {r_rdrf, r_orfe, r_tdre, r_ctl};

    always_comb begin
        RDATA = 8'h00;
        if (w_rd) begin
            case (w_reg)
                c_OFF_RMCR:  RDATA = r_rmcr;
                c_OFF_TRCSR: RDATA = w_trcsr;
                c_OFF_RDR:   RDATA = r_rdr;
                c_OFF_TDR:   RDATA = r_tdr;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Baud generator
    // ------------------------------------------------------------------
    logic w_sample_tick, w_bit_tick;

    hd63701_sci_baud u_baud (
        .i_clk         (CLK),
        .i_rst         (RST),
        .i_clr         (w_rmcr_wr),
        .i_ss          (r_rmcr[1:0]),
        .o_sample_tick (w_sample_tick),
        .o_bit_tick    (w_bit_tick)
    );

    // ------------------------------------------------------------------
    // RXD synchroniser (idle-high line, so flops reset to 1)
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   w_rxd;

    always_ff @(posedge CLK) begin
        if (RST) r_sync <= '1;
        else     r_sync <= {r_sync[SYNC_STAGES-2:0], RXD};
    end

    assign w_rxd = r_sync[SYNC_STAGES-1];

    // ------------------------------------------------------------------
    // FSM event strobes
    // ------------------------------------------------------------------
    tx_state_e  r_tx_state;
    rx_state_e  r_rx_state;
    logic [7:0] r_tx_shift, r_rx_shift;
    logic [2:0] r_tx_cnt, r_rx_bit;
    logic [3:0] r_rx_cnt;
    logic       r_txd;

    logic w_tx_load, w_rx_stop_smp, w_rx_ok, w_rx_err;

    assign w_tx_load = w_bit_tick && r_ctl[c_BIT_TE] && !r_tdre &&
                       ((r_tx_state == TX_IDLE) || (r_tx_state == TX_STOP));

    assign w_rx_stop_smp = w_sample_tick && r_ctl[c_BIT_RE] &&
                           (r_rx_state == RX_STOP) && (r_rx_cnt == 4'hF);
    assign w_rx_ok  = w_rx_stop_smp && w_rxd && !r_rdrf;
    assign w_rx_err = w_rx_stop_smp && (!w_rxd || r_rdrf);

    // Hardware flag sets come after software clears so a same-cycle set wins
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_rmcr   <= 8'h00;
            r_ctl    <= 5'd0;
            r_rdrf   <= 1'b0;
            r_orfe   <= 1'b0;
            r_tdre   <= 1'b1;
            r_rdr    <= 8'h00;
            r_tdr    <= 8'h00;
            r_rx_arm <= 1'b0;
            r_tx_arm <= 1'b0;
            r_irq    <= 1'b0;
        end else begin
            if (w_rmcr_wr)  r_rmcr <= WDATA;
            if (w_trcsr_wr) r_ctl  <= WDATA[4:0];
            if (w_tdr_wr)   r_tdr  <= WDATA;

            if (w_acc) begin
                r_rx_arm <= w_trcsr_rd && (r_rdrf || r_orfe);
                r_tx_arm <= w_trcsr_rd && r_tdre;
            end

            if (w_rdr_rd && r_rx_arm) begin
                r_rdrf <= 1'b0;
                r_orfe <= 1'b0;
            end
            if (w_tdr_wr && r_tx_arm) r_tdre <= 1'b0;

            if (w_rx_ok) begin
                r_rdr  <= r_rx_shift;
                r_rdrf <= 1'b1;
            end
            if (w_rx_err)  r_orfe <= 1'b1;
            if (w_tx_load) r_tdre <= 1'b1;

            r_irq <= (r_ctl[c_BIT_RIE] && (r_rdrf || r_orfe)) ||
                     (r_ctl[c_BIT_TIE] && r_tdre);
        end
    end

    assign IRQ = r_irq;

    // ------------------------------------------------------------------
    // Transmit FSM, advances on bit ticks
    // ------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_tx_state <= TX_IDLE;
            r_tx_shift <= 8'h00;
            r_tx_cnt   <= 3'd0;
            r_txd      <= 1'b1;
        end else if (w_bit_tick) begin
            case (r_tx_state)
                TX_IDLE: begin
                    if (w_tx_load) begin
                        r_tx_shift <= r_tdr;
                        r_txd      <= 1'b0;
                        r_tx_state <= TX_START;
                    end
                end
                TX_START: begin
                    r_txd      <= r_tx_shift[0];
                    r_tx_shift <= {1'b0, r_tx_shift[7:1]};
                    r_tx_cnt   <= 3'd0;
                    r_tx_state <= TX_DATA;
                end
                TX_DATA: begin
                    if (r_tx_cnt == 3'd7) begin
                        r_txd      <= 1'b1;
                        r_tx_state <= TX_STOP;
                    end else begin
                        r_txd      <= r_tx_shift[0];
                        r_tx_shift <= {1'b0, r_tx_shift[7:1]};
                        r_tx_cnt   <= r_tx_cnt + 3'd1;
                    end
                end
                TX_STOP: begin
                    // Back-to-back frames skip IDLE when TDR is already pending
                    if (w_tx_load) begin
                        r_tx_shift <= r_tdr;
                        r_txd      <= 1'b0;
                        r_tx_state <= TX_START;
                    end else begin
                        r_tx_state <= TX_IDLE;
                    end
                end
                default: r_tx_state <= TX_IDLE;
            endcase
        end
    end

    assign TXD = r_txd;

    // ------------------------------------------------------------------
    // Receive FSM, runs on sample ticks, aborted at once when RE drops
    // ------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_rx_state <= RX_IDLE;
            r_rx_cnt   <= 4'd0;
            r_rx_bit   <= 3'd0;
            r_rx_shift <= 8'h00;
        end else if (!r_ctl[c_BIT_RE]) begin
            r_rx_state <= RX_IDLE;
        end else if (w_sample_tick) begin
            case (r_rx_state)
                RX_IDLE: begin
                    if (!w_rxd) begin
                        r_rx_cnt   <= 4'd0;
                        r_rx_state <= RX_START;
                    end
                end
                RX_START: begin
                    if (r_rx_cnt == 4'd7) begin
                        r_rx_cnt   <= 4'd0;
                        r_rx_bit   <= 3'd0;
                        r_rx_state <= w_rxd ? RX_IDLE : RX_DATA;
                    end else begin
                        r_rx_cnt <= r_rx_cnt + 4'd1;
                    end
                end
                RX_DATA: begin
                    if (r_rx_cnt == 4'hF) begin
                        r_rx_shift <= {w_rxd, r_rx_shift[7:1]};
                        r_rx_cnt   <= 4'd0;
                        if (r_rx_bit == 3'd7) r_rx_state <= RX_STOP;
                        else                  r_rx_bit   <= r_rx_bit + 3'd1;
                    end else begin
                        r_rx_cnt <= r_rx_cnt + 4'd1;
                    end
                end
                RX_STOP: begin
                    if (r_rx_cnt == 4'hF) begin
                        r_rx_cnt   <= 4'd0;
                        r_rx_state <= RX_IDLE;
                    end else begin
                        r_rx_cnt <= r_rx_cnt + 4'd1;
                    end
                end
                default: r_rx_state <= RX_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_hd63701_sci.sv
`default_nettype none
// ============================================================================
// Module  : tb_hd63701_sci
// Brief   : Directed self-checking bench for hd63701_sci (SCI at BASE 0x0010).
// Revision: 1.0
// ============================================================================
module tb_hd63701_sci;

    localparam logic [15:0] c_RMCR  = 16'h0010;
    localparam logic [15:0] c_TRCSR = 16'h0011;
    localparam logic [15:0] c_RDR   = 16'h0012;
    localparam logic [15:0] c_TDR   = 16'h0013;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        BUS_EN = 1'b0;
    logic [15:0] AD = 16'h0000;
    logic        RW = 1'b1;
    logic [7:0]  WDATA = 8'h00;
    logic [7:0]  RDATA;
    logic        SEL;
    logic        IRQ;
    logic        RXD = 1'b1;
    logic        TXD;

    int n_pass  = 0;
    int n_fail  = 0;
    int n_total = 0;

    hd63701_sci #(.BASE(16'h0010), .SYNC_STAGES(2)) dut (
        .CLK    (CLK),
        .RST    (RST),
        .BUS_EN (BUS_EN),
        .AD     (AD),
        .RW     (RW),
        .WDATA  (WDATA),
        .RDATA  (RDATA),
        .SEL    (SEL),
        .IRQ    (IRQ),
        .RXD    (RXD),
        .TXD    (TXD)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic rd(input logic [15:0] a, output logic [7:0] d, output logic s);
        @(negedge CLK);
        BUS_EN = 1'b1; AD = a; RW = 1'b1;
        #1 d = RDATA; s = SEL;
        @(posedge CLK);
        #1 BUS_EN = 1'b0;
    endtask

    task automatic rdchk(input string tag, input logic [15:0] a, input logic [7:0] exp);
        logic [7:0] d;
        logic       s;
        rd(a, d, s);
        chk(tag, {8'h00, d}, {8'h00, exp});
    endtask

    task automatic wr(input logic [15:0] a, input logic [7:0] d);
        @(negedge CLK);
        BUS_EN = 1'b1; AD = a; RW = 1'b0; WDATA = d;
        @(posedge CLK);
        #1 BUS_EN = 1'b0; RW = 1'b1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stopb);
        @(negedge CLK);
        RXD = 1'b0;
        repeat (16) @(negedge CLK);
        for (int i = 0; i < 8; i++) begin
            RXD = b[i];
            repeat (16) @(negedge CLK);
        end
        RXD = stopb;
        repeat (16) @(negedge CLK);
        RXD = 1'b1;
    endtask

    initial begin : stim
        logic [7:0] d;
        logic       s;
        logic [7:0] bits;
        int         cnt;
        logic       saw_low;

        // Reset state
        repeat (3) @(negedge CLK);
        chk("rst_txd", {15'd0, TXD}, 16'd1);
        chk("rst_irq", {15'd0, IRQ}, 16'd0);
        RST = 1'b0;
        rd(c_TRCSR, d, s);
        chk("rst_trcsr", {8'h00, d}, 16'h0020);
        chk("sel_hit", {15'd0, s}, 16'd1);
        rdchk("rst_rmcr", c_RMCR, 8'h00);
        rdchk("rst_rdr", c_RDR, 8'h00);
        rdchk("rst_tdr", c_TDR, 8'h00);
        rd(16'h0014, d, s);
        chk("sel_miss", {15'd0, s}, 16'd0);
        chk("rdata_miss", {8'h00, d}, 16'h0000);

        // TDR write without a preceding TRCSR read: TDRE stays set, no frame
        wr(c_TRCSR, 8'h02);
        wr(c_TDR, 8'h55);
        saw_low = 1'b0;
        repeat (40) begin
            @(negedge CLK);
            if (TXD !== 1'b1) saw_low = 1'b1;
        end
        chk("noarm_no_frame", {15'd0, saw_low}, 16'd0);
        rdchk("noarm_trcsr", c_TRCSR, 8'h22);
        rdchk("noarm_tdr", c_TDR, 8'h55);

        // Transmit 0xA5 at SS=00 with TIE
        wr(c_TRCSR, 8'h06);
        rdchk("tx_trcsr_pre", c_TRCSR, 8'h26);
        chk("tx_irq_tdre", {15'd0, IRQ}, 16'd1);
        wr(c_TDR, 8'hA5);
        cnt = 0;
        while (TXD !== 1'b0 && cnt < 64) begin
            @(negedge CLK);
            cnt++;
        end
        chk("tx_start_seen", {15'd0, TXD}, 16'd0);
        chk("tx_tdre_at_start", {15'd0, dut.r_tdre}, 16'd1);
        chk("tx_irq_lag", {15'd0, IRQ}, 16'd0);
        @(negedge CLK);
        chk("tx_irq_rise", {15'd0, IRQ}, 16'd1);
        repeat (14) @(negedge CLK);
        chk("tx_start_len", {15'd0, TXD}, 16'd0);
        @(negedge CLK);
        chk("tx_bit0_edge", {15'd0, TXD}, 16'd1);
        repeat (8) @(negedge CLK);
        for (int k = 0; k < 8; k++) begin
            bits[k] = TXD;
            repeat (16) @(negedge CLK);
        end
        chk("tx_stop", {15'd0, TXD}, 16'd1);
        chk("tx_data", {8'h00, bits}, 16'h00A5);
        repeat (16) @(negedge CLK);

        // Receive 0x3C with RIE
        wr(c_TRCSR, 8'h18);
        send_byte(8'h3C, 1'b1);
        repeat (4) @(negedge CLK);
        chk("rx_irq", {15'd0, IRQ}, 16'd1);
        rdchk("rx_trcsr", c_TRCSR, 8'hB8);
        rdchk("rx_rdr", c_RDR, 8'h3C);
        rdchk("rx_trcsr_clr", c_TRCSR, 8'h38);
        chk("rx_irq_clr", {15'd0, IRQ}, 16'd0);

        // Overrun: second byte lost, first retained
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b1);
        repeat (4) @(negedge CLK);
        rdchk("ovr_trcsr", c_TRCSR, 8'hF8);
        rdchk("ovr_rdr", c_RDR, 8'h11);
        rdchk("ovr_trcsr_clr", c_TRCSR, 8'h38);

        // Framing error: stop bit low
        send_byte(8'h5A, 1'b0);
        repeat (24) @(negedge CLK);
        rdchk("fe_trcsr", c_TRCSR, 8'h78);
        rdchk("fe_rdr", c_RDR, 8'h11);
        rdchk("fe_trcsr_clr", c_TRCSR, 8'h38);

        // False start, then a good byte proves the receiver idled
        @(negedge CLK);
        RXD = 1'b0;
        repeat (4) @(negedge CLK);
        RXD = 1'b1;
        repeat (30) @(negedge CLK);
        rdchk("glitch_trcsr", c_TRCSR, 8'h38);
        chk("glitch_irq", {15'd0, IRQ}, 16'd0);
        send_byte(8'h81, 1'b1);
        repeat (4) @(negedge CLK);
        rdchk("glitch_next_trcsr", c_TRCSR, 8'hB8);
        rdchk("glitch_next_rdr", c_RDR, 8'h81);

        // SS=10: bit time 1024 CLK
        wr(c_RMCR, 8'h02);
        rdchk("ss10_rmcr", c_RMCR, 8'h02);
        wr(c_TRCSR, 8'h02);
        rdchk("ss10_trcsr", c_TRCSR, 8'h22);
        wr(c_TDR, 8'h01);
        cnt = 0;
        while (TXD !== 1'b0 && cnt < 2100) begin
            @(negedge CLK);
            cnt++;
        end
        chk("ss10_start_seen", {15'd0, TXD}, 16'd0);
        cnt = 0;
        while (TXD === 1'b0 && cnt < 1100) begin
            @(negedge CLK);
            cnt++;
        end
        chk("ss10_bit_time", 16'(cnt), 16'd1024);

        // Reset in the middle of data bit 1 (a zero bit)
        repeat (1100) @(negedge CLK);
        chk("midtx_low", {15'd0, TXD}, 16'd0);
        RST = 1'b1;
        @(negedge CLK);
        chk("midtx_rst_txd", {15'd0, TXD}, 16'd1);
        RST = 1'b0;
        rdchk("midtx_rmcr", c_RMCR, 8'h00);
        rdchk("midtx_trcsr", c_TRCSR, 8'h20);
        chk("midtx_irq", {15'd0, IRQ}, 16'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
